// File: rtl/spi_target.sv
// SPI mode-0 target: lets an external host peek/poke a 128-entry window
// through a simple strobe bus. All SPI pins are oversampled in clk.
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_MISO   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [6:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic       busy
);

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        S_WAIT_CS,
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic                cap_q, cap_d;
    logic                ld_pend_q, ld_pend_d;
    logic                busy_q, busy_d;
    logic                oe_q, oe_d;

    logic              sclk_s, cs_n_s, mosi_s;
    logic              rise, fall, byte_done;
    logic [DATA_W-1:0] rx_byte;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Synchronizer shift chains and sclk history for edge detection
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_hist_d = sclk_s;
    end

    assign rise      = ~cs_n_s & sclk_s & ~sclk_hist_q;
    assign fall      = ~cs_n_s & ~sclk_s & sclk_hist_q;
    assign rx_byte   = {rx_q, mosi_s};
    assign byte_done = rise && (bit_cnt_q == CNT_W'(7));

    // Frame decode, bus strobes, address stepping and MISO shifter
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        hold_d    = hold_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        cap_d     = re_q;
        ld_pend_d = ld_pend_q;

        // Read data arrives the cycle after the strobe; step past it afterwards
        if (cap_q) begin
            hold_d = bus_rdata;
            addr_d = addr_q + ADDR_W'(1);
        end
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            S_WAIT_CS: begin
                if (cs_n_s) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!cs_n_s) begin
                    state_d   = S_CMD;
                    tx_d      = IDLE_MISO;
                    bit_cnt_d = '0;
                    ld_pend_d = 1'b0;
                end
            end
            default: begin
                if (cs_n_s) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                    ld_pend_d = 1'b0;
                end else begin
                    if (rise) begin
                        rx_d      = rx_byte[DATA_W-2:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (fall) begin
                        if (ld_pend_q) begin
                            tx_d      = (state_q == S_RD) ? hold_q : IDLE_MISO;
                            ld_pend_d = 1'b0;
                        end else begin
                            tx_d = {tx_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    if (byte_done) begin
                        ld_pend_d = 1'b1;
                        case (state_q)
                            S_CMD: begin
                                addr_d = rx_byte[ADDR_W-1:0];
                                if (rx_byte[DATA_W-1]) begin
                                    state_d = S_WR;
                                end else begin
                                    state_d = S_RD;
                                    re_d    = 1'b1;
                                end
                            end
                            S_WR: begin
                                wdata_d = rx_byte;
                                we_d    = 1'b1;
                            end
                            S_RD: begin
                                re_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        busy_d = (state_d == S_CMD) || (state_d == S_WR) || (state_d == S_RD);
        oe_d   = ~cs_n_s;
    end

    // State register; cs_n chain resets low so a frame in progress at reset
    // must see a real cs_n high before it can be decoded
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            state_q     <= S_WAIT_CS;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            hold_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            cap_q       <= 1'b0;
            ld_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_hist_q <= sclk_hist_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            hold_q      <= hold_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            cap_q       <= cap_d;
            ld_pend_q   <= ld_pend_d;
            busy_q      <= busy_d;
            oe_q        <= oe_d;
        end
    end

    assign spi_miso    = tx_q[DATA_W-1];
    assign spi_miso_oe = oe_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_we      = we_q;
    assign bus_re      = re_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI host model drives frames and a
// registered bus model answers reads with addr ^ 0x5A.
module tb_spi_target;

    localparam int HP = 40;  // half sclk period = 4 clk -> sclk = clk/8

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [6:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata = 8'h00;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int both_cnt = 0;

    logic [7:0] we_a[$];
    logic [7:0] we_v[$];
    logic [7:0] re_a[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    spi_target dut (
        .clk        (clk),
        .reset      (reset),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .bus_rdata  (bus_rdata),
        .busy       (busy)
    );

    // Registered memory model: data valid one clk after bus_re
    always @(posedge clk) begin
        if (bus_re) bus_rdata <= {1'b0, bus_addr} ^ 8'h5A;
    end

    // Strobe monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_we) begin
                we_a.push_back({1'b0, bus_addr});
                we_v.push_back(bus_wdata);
            end
            if (bus_re) re_a.push_back({1'b0, bus_addr});
            if (bus_we && bus_re) both_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] qget(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 8'hEE;
    endfunction

    task automatic mon_clear();
        we_a.delete();
        we_v.delete();
        re_a.delete();
    endtask

    // phase keeps every host transition away from a clk edge
    task automatic cs_assert(input int phase);
        @(posedge clk);
        #phase;
        spi_cs_n = 1'b0;
    endtask

    task automatic cs_release();
        #HP;
        spi_cs_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            #HP;
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            #HP;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int phase);
        logic [7:0] r;
        rxq.delete();
        cs_assert(phase);
        for (int i = 0; i < txq.size(); i++) begin
            spi_bits(txq[i], 8, r);
            rxq.push_back(r);
            if (i == 0) begin
                check_eq("busy_in_frame", 32'(busy), 32'd1);
                check_eq("oe_in_frame", 32'(spi_miso_oe), 32'd1);
            end
        end
        cs_release();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"}, 32'(spi_miso), 32'd0);
        check_eq({tag, "_oe"}, 32'(spi_miso_oe), 32'd0);
        check_eq({tag, "_addr"}, 32'(bus_addr), 32'd0);
        check_eq({tag, "_wdata"}, 32'(bus_wdata), 32'd0);
        check_eq({tag, "_we"}, 32'(bus_we), 32'd0);
        check_eq({tag, "_re"}, 32'(bus_re), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int ph;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        repeat (8) @(posedge clk);

        // Write burst
        mon_clear();
        txq.delete(); txq.push_back(8'h90); txq.push_back(8'h11); txq.push_back(8'h22);
        spi_frame(3);
        check_eq("wr_we_count", 32'(we_a.size()), 32'd2);
        check_eq("wr_addr0", 32'(qget(we_a, 0)), 32'h10);
        check_eq("wr_data0", 32'(qget(we_v, 0)), 32'h11);
        check_eq("wr_addr1", 32'(qget(we_a, 1)), 32'h11);
        check_eq("wr_data1", 32'(qget(we_v, 1)), 32'h22);
        check_eq("wr_re_count", 32'(re_a.size()), 32'd0);
        for (int i = 0; i < 3; i++) check_eq($sformatf("wr_miso%0d", i), 32'(qget(rxq, i)), 32'h00);
        check_eq("wr_busy_after", 32'(busy), 32'd0);
        check_eq("wr_oe_after", 32'(spi_miso_oe), 32'd0);

        // Read burst
        mon_clear();
        txq.delete(); txq.push_back(8'h10); txq.push_back(8'h00); txq.push_back(8'h00);
        spi_frame(7);
        check_eq("rd_miso_cmd", 32'(qget(rxq, 0)), 32'h00);
        check_eq("rd_miso0", 32'(qget(rxq, 1)), 32'h4A);
        check_eq("rd_miso1", 32'(qget(rxq, 2)), 32'h4B);
        check_eq("rd_re_count", 32'(re_a.size()), 32'd3);
        check_eq("rd_re_addr0", 32'(qget(re_a, 0)), 32'h10);
        check_eq("rd_re_addr1", 32'(qget(re_a, 1)), 32'h11);
        check_eq("rd_re_addr2", 32'(qget(re_a, 2)), 32'h12);
        check_eq("rd_we_count", 32'(we_a.size()), 32'd0);

        // Address wrap
        mon_clear();
        txq.delete(); txq.push_back(8'hFF); txq.push_back(8'hAA); txq.push_back(8'hBB);
        spi_frame(2);
        check_eq("wrap_we_count", 32'(we_a.size()), 32'd2);
        check_eq("wrap_addr0", 32'(qget(we_a, 0)), 32'h7F);
        check_eq("wrap_data0", 32'(qget(we_v, 0)), 32'hAA);
        check_eq("wrap_addr1", 32'(qget(we_a, 1)), 32'h00);
        check_eq("wrap_data1", 32'(qget(we_v, 1)), 32'hBB);

        // Abort with a partial data byte
        mon_clear();
        cs_assert(4);
        spi_bits(8'h85, 8, r);
        spi_bits(8'hC3, 5, r);
        cs_release();
        check_eq("abort_we_count", 32'(we_a.size()), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        txq.delete(); txq.push_back(8'h85); txq.push_back(8'h33);
        spi_frame(6);
        check_eq("post_abort_we_count", 32'(we_a.size()), 32'd1);
        check_eq("post_abort_addr", 32'(qget(we_a, 0)), 32'h05);
        check_eq("post_abort_data", 32'(qget(we_v, 0)), 32'h33);

        // Reset mid-frame, then sclk activity with cs_n still low
        mon_clear();
        cs_assert(1);
        spi_bits(8'h91, 3, r);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        #2;
        spi_bits(8'hFF, 5, r);
        spi_bits(8'h81, 8, r);
        check_eq("ignored_busy", 32'(busy), 32'd0);
        cs_release();
        check_eq("ignored_we_count", 32'(we_a.size()), 32'd0);
        check_eq("ignored_re_count", 32'(re_a.size()), 32'd0);
        txq.delete(); txq.push_back(8'h83); txq.push_back(8'h44);
        spi_frame(8);
        check_eq("post_rst_we_count", 32'(we_a.size()), 32'd1);
        check_eq("post_rst_addr", 32'(qget(we_a, 0)), 32'h03);
        check_eq("post_rst_data", 32'(qget(we_v, 0)), 32'h44);

        // Rate limit: sclk = clk/8, random phase, 16-byte read bursts crossing the wrap
        for (int run = 0; run < 2; run++) begin
            mon_clear();
            txq.delete();
            txq.push_back(8'h78);
            for (int i = 0; i < 16; i++) txq.push_back(8'h00);
            ph = int'($urandom_range(1, 4)) + (($urandom_range(0, 1) == 1) ? 5 : 0);
            spi_frame(ph);
            check_eq($sformatf("rate%0d_miso_cmd", run), 32'(qget(rxq, 0)), 32'h00);
            for (int i = 0; i < 16; i++) begin
                check_eq($sformatf("rate%0d_byte%0d", run, i), 32'(qget(rxq, i + 1)),
                         32'((8'(8'h78 + i) & 8'h7F) ^ 8'h5A));
            end
            check_eq($sformatf("rate%0d_re_count", run), 32'(re_a.size()), 32'd17);
        end

        check_eq("we_re_overlap", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
